reg_file_wb: RTL

Write-back register file for the single-issue MIPS core. Sits directly downstream of the 32-bit three-input write-back select mux: it consumes the mux's selected result, the same `sel_0`/`sel_1` select pair, and the destination register number. It stores the 32 × 32-bit architectural GPRs and serves the two operand reads for decode. It forces the JAL link destination to `$31`, keeps `$0` at zero, and flags the illegal select code.

---
 rtl/mips_pkg.sv | 17 +
 rtl/reg_file_wb_if.sv | 31 +++
 rtl/wb_dest_resolve.sv | 37 +++
 rtl/reg_file_wb.sv | 80 ++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: write-back select encoding and GPR constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_pkg;

  typedef enum logic [1:0] {
    WB_ALU     = 2'b00,
    WB_MEM     = 2'b01,
    WB_LINK    = 2'b10,
    WB_ILLEGAL = 2'b11
  } wb_sel_t;

  localparam int REG_ZERO   = 0;
  localparam int REG_RA     = 31;
  localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/reg_file_wb_if.sv
// Write-back / operand-read bundle between the MEM/WB stage, decode and the GPR file.
// Latency: n/a (wiring only).
// Backpressure: none; write-back is sampled every edge, reads are combinational.
interface reg_file_wb_if #(
  parameter int DATA_W = 32,
  parameter int AW     = 5
);
  logic              wb_en;
  logic              sel_0;
  logic              sel_1;
  logic [AW-1:0]     wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [AW-1:0]     rd_addr_a;
  logic [AW-1:0]     rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              sel_err;
  logic [15:0]       wr_count;

  // Pipeline side: drives write-back and read addresses, consumes read data.
  modport master (
    output wb_en, sel_0, sel_1, wb_addr, wb_data, rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b, sel_err, wr_count
  );

  // Register file side.
  modport slave (
    input  wb_en, sel_0, sel_1, wb_addr, wb_data, rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b, sel_err, wr_count
  );
endinterface

// File: rtl/wb_dest_resolve.sv
// Resolves write-back destination, commit strobe and illegal-select strobe (shared with hazard unit).
// Latency: purely combinational.
// Backpressure: none.
module wb_dest_resolve
  import mips_pkg::*;
#(
  parameter int AW       = 5,
  parameter int LINK_REG = REG_RA
) (
  input  logic          wb_en_i,
  input  logic          sel_0_i,
  input  logic          sel_1_i,
  input  logic [AW-1:0] wb_addr_i,
  output logic [AW-1:0] dest_o,
  output logic          commit_o,
  output logic          illegal_o
);

  localparam logic [AW-1:0] LINK_A = AW'(LINK_REG);
  localparam logic [AW-1:0] ZERO_A = AW'(REG_ZERO);

  wb_sel_t sel;

  // Decode the select pair; JAL overrides the destination, code 11 never commits
  always_comb begin
    sel       = wb_sel_t'({sel_1_i, sel_0_i});
    dest_o    = wb_addr_i;
    illegal_o = 1'b0;
    case (sel)
      WB_LINK:    dest_o    = LINK_A;
      WB_ILLEGAL: illegal_o = wb_en_i;
      default:    ;
    endcase
    commit_o = wb_en_i && (sel != WB_ILLEGAL) && (dest_o != ZERO_A);
  end

endmodule

// File: rtl/reg_file_wb.sv
// Write-back GPR file: 2 combinational reads, 1 write with $0 hardwired, JAL link, sticky illegal-select flag.
// Latency: write visible one cycle after the commit edge (same cycle when REGFILE_WB_BYPASS_EN is defined).
// Backpressure: none; wb_en is sampled every edge and writes are never stalled.
module reg_file_wb
  import mips_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NREGS    = 32,
  parameter int LINK_REG = REG_RA
) (
  input  logic          clk,
  input  logic          rst,
  reg_file_wb_if.slave  bus
);

  localparam int            AW     = $clog2(NREGS);
  localparam logic [AW-1:0] ZERO_A = AW'(REG_ZERO);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic              sel_err_q, sel_err_d;
  logic [15:0]       wr_count_q, wr_count_d;

  logic [AW-1:0]     dest;
  logic              commit;
  logic              illegal;

  wb_dest_resolve #(
    .AW       (AW),
    .LINK_REG (LINK_REG)
  ) u_dest (
    .wb_en_i   (bus.wb_en),
    .sel_0_i   (bus.sel_0),
    .sel_1_i   (bus.sel_1),
    .wb_addr_i (bus.wb_addr),
    .dest_o    (dest),
    .commit_o  (commit),
    .illegal_o (illegal)
  );

  // Sticky illegal-select flag and saturating committed-write counter
  always_comb begin
    sel_err_d  = sel_err_q | illegal;
    wr_count_d = wr_count_q;
    if (commit && (wr_count_q != 16'hFFFF)) begin
      wr_count_d = wr_count_q + 16'd1;
    end
  end

  // GPR array and status state; reset clears everything asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      sel_err_q  <= 1'b0;
      wr_count_q <= '0;
    end else begin
      if (commit) begin
        regs_q[dest] <= bus.wb_data;
      end
      sel_err_q  <= sel_err_d;
      wr_count_q <= wr_count_d;
    end
  end

  // Operand reads; $0 is forced to zero, optional write-through of the committing value
  always_comb begin
    bus.rd_data_a = (bus.rd_addr_a == ZERO_A) ? '0 : regs_q[bus.rd_addr_a];
    bus.rd_data_b = (bus.rd_addr_b == ZERO_A) ? '0 : regs_q[bus.rd_addr_b];
`ifdef REGFILE_WB_BYPASS_EN
    // commit already excludes $0 and select 11, so neither is ever forwarded
    if (commit && (bus.rd_addr_a == dest)) bus.rd_data_a = bus.wb_data;
    if (commit && (bus.rd_addr_b == dest)) bus.rd_data_b = bus.wb_data;
`endif
  end

  assign bus.sel_err  = sel_err_q;
  assign bus.wr_count = wr_count_q;

endmodule
